// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, optional borrow-in via SERIAL_SUB_BIN_EN
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             bin,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_borrow_out;
    logic [CW-1:0]    r_cnt;

    logic             w_bin;
    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_borrow_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_BIN_EN
    assign w_bin = bin;
`else
    assign w_bin = 1'b0;
`endif

    // Full-subtractor on the current operand LSBs and the running borrow
    assign w_x           = r_a[0];
    assign w_y           = r_b[0];
    assign w_d           = w_x ^ w_y ^ r_borrow;
    assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_last        = (r_cnt == LAST_BIT);
    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_res_next    = {w_d, r_res[WIDTH-1:1]};

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

    // State register; reset forces IDLE immediately so ready rises without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs decoded from the current state
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand/result shifting, borrow tracking and result capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= w_bin;
            r_cnt    <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res_next;
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff       <= w_res_next;
                r_borrow_out <= w_borrow_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
`ifdef SERIAL_SUB_BIN_EN
        .bin        (bin_i),
`endif
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned subtraction taken as a 9-bit two's-complement value
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    endfunction

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tbin);
        logic [WIDTH:0] exp;
        int done_cyc;
        int n_done;
        bit busy_ok;
        @(negedge clk);
        a_i   = ta;
        b_i   = tb_v;
        bin_i = tbin;
        start = 1'b1;
        check({tag, ":ready_before"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_i   = WIDTH'($urandom);
        b_i   = WIDTH'($urandom);
        bin_i = 1'($urandom);
        exp      = ref_sub(ta, tb_v, tbin);
        done_cyc = 0;
        n_done   = 0;
        busy_ok  = 1'b1;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            @(negedge clk);
            if (c <= WIDTH && busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == WIDTH + 1) begin
                check({tag, ":diff"}, 32'(diff), 32'(exp[WIDTH-1:0]));
                check({tag, ":borrow"}, 32'(borrow_out), 32'(exp[WIDTH]));
            end
            if (c == WIDTH + 2) begin
                check({tag, ":ready_after"}, 32'(ready), 32'd1);
                check({tag, ":diff_hold"}, 32'(diff), 32'(exp[WIDTH-1:0]));
            end
        end
        check({tag, ":done_cycle"}, 32'(done_cyc), 32'(WIDTH + 1));
        check({tag, ":done_count"}, 32'(n_done), 32'd1);
        check({tag, ":busy_window"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        int n_done;
        int wait_cyc;
        logic rb;

        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        bin_i = 1'b0;
        #1;
        check("rst:ready", 32'(ready), 32'd1);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:diff", 32'(diff), 32'd0);
        check("rst:borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic_05_03", 8'h05, 8'h03, 1'b0);
        run_op("neg_03_05", 8'h03, 8'h05, 1'b0);
        run_op("under_00_ff", 8'h00, 8'hFF, 1'b0);
        run_op("equal_a5", 8'hA5, 8'hA5, 1'b0);

        // start held high while busy: no reload, one done, then re-accept once ready
        @(negedge clk);
        a_i   = 8'h10;
        b_i   = 8'h01;
        bin_i = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_i = 8'hFF;
        b_i = 8'h00;
        n_done = 0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (c == WIDTH + 1) begin
                check("held:diff", 32'(diff), 32'h0F);
                check("held:borrow", 32'(borrow_out), 32'd0);
                check("held:ready_in_done", 32'(ready), 32'd0);
            end
        end
        check("held:done_count", 32'(n_done), 32'd1);
        @(negedge clk);
        check("held:ready_back", 32'(ready), 32'd1);
        @(negedge clk);
        check("held:reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_cyc = 0;
        while (done !== 1'b1 && wait_cyc < 3 * WIDTH) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("held:second_done_seen", 32'(done), 32'd1);
        check("held:second_diff", 32'(diff), 32'hFF);
        check("held:second_borrow", 32'(borrow_out), 32'd0);

        // asynchronous reset in the middle of SHIFT aborts the operation
        @(negedge clk);
        a_i   = 8'h55;
        b_i   = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort:busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort:ready", 32'(ready), 32'd1);
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:done", 32'(done), 32'd0);
        check("abort:diff", 32'(diff), 32'd0);
        check("abort:borrow", 32'(borrow_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort:no_done", 32'(n_done), 32'd0);
        run_op("after_rst_09_04", 8'h09, 8'h04, 1'b0);

`ifdef SERIAL_SUB_BIN_EN
        run_op("bin_05_03", 8'h05, 8'h03, 1'b1);
        run_op("bin_00_00", 8'h00, 8'h00, 1'b1);
`endif

        for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_SUB_BIN_EN
            rb = 1'($urandom);
`else
            rb = 1'b0;
`endif
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
